// File: rtl/fma_pkg.sv
// Shared FMA sizing: default field widths and the derived datapath lengths.
package fma_pkg;

    localparam int unsigned NF_DEF = 52;
    localparam int unsigned NE_DEF = 11;

    function automatic int unsigned fma_len(input int unsigned nf);
        return 3 * nf + 6;
    endfunction

    function automatic int unsigned pm_len(input int unsigned nf);
        return 2 * nf + 2;
    endfunction

    localparam int unsigned FMALEN = fma_len(NF_DEF);
    localparam int unsigned PMLEN  = pm_len(NF_DEF);

endpackage

// File: rtl/fmaaddsum.sv
// Combinational FMA effective add/subtract: sum magnitude, sign and exponent select.
module fmaaddsum
    import fma_pkg::*;
#(
    parameter int unsigned NF = NF_DEF,
    parameter int unsigned NE = NE_DEF
) (
    input  logic [fma_len(NF)-1:0] am_i,
    input  logic                   asticky_i,
    input  logic                   kill_prod_i,
    input  logic [pm_len(NF)-1:0]  pm_i,
    input  logic                   ps_i,
    input  logic                   zs_i,
    input  logic [NE+1:0]          pe_i,
    input  logic [NE-1:0]          ze_i,
    output logic [fma_len(NF)-1:0] sm_o,
    output logic                   ss_o,
    output logic [NE+1:0]          se_o,
    output logic                   neg_sum_o,
    output logic                   inv_a_o
);

    localparam int unsigned FmaLen = fma_len(NF);
    localparam int unsigned PmLen  = pm_len(NF);

    logic [PmLen-1:0]  pm_killed;
    logic [FmaLen-1:0] pm_al;
    logic [FmaLen:0]   pre_sum;
    logic [FmaLen-1:0] neg_pre_sum;
    logic              inv_a;

    assign inv_a     = ps_i ^ zs_i;
    assign pm_killed = kill_prod_i ? '0 : pm_i;
    assign pm_al     = {{(NF + 2){1'b0}}, pm_killed, 2'b00};

    // The sticky bit makes the true addend slightly larger than Am, which
    // suppresses the +1 of the two's complement in whichever direction subtracts it.
    assign pre_sum = {inv_a, inv_a ? ~am_i : am_i} + {1'b0, pm_al}
                   + {{FmaLen{1'b0}}, inv_a & ~asticky_i & ~kill_prod_i};
    // Only the low bits are ever selected, so the carry column is not built.
    assign neg_pre_sum = am_i + ~pm_al + {{(FmaLen - 1){1'b0}}, ~asticky_i | kill_prod_i};

    assign neg_sum_o = pre_sum[FmaLen];
    assign sm_o      = neg_sum_o ? neg_pre_sum : pre_sum[FmaLen-1:0];
    assign ss_o      = neg_sum_o ^ ps_i;
    assign se_o      = kill_prod_i ? {2'b00, ze_i} : pe_i;
    assign inv_a_o   = inv_a;

endmodule

// File: rtl/fmaaddpipe.sv
// Two-stage valid/ready FMA sum stage: S1 holds operands, S2 holds the resolved sum.
module fmaaddpipe
    import fma_pkg::*;
#(
    parameter int unsigned NF   = NF_DEF,
    parameter int unsigned NE   = NE_DEF,
    parameter int unsigned TAGW = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [fma_len(NF)-1:0] Am,
    input  logic                   ASticky,
    input  logic                   KillProd,
    input  logic [pm_len(NF)-1:0]  Pm,
    input  logic                   Ps,
    input  logic                   Zs,
    input  logic [NE+1:0]          Pe,
    input  logic [NE-1:0]          Ze,
    input  logic [TAGW-1:0]        tag_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [fma_len(NF)-1:0] Sm,
    output logic                   Ss,
    output logic [NE+1:0]          Se,
    output logic                   NegSum,
    output logic                   InvA,
    output logic                   ASticky_o,
    output logic [TAGW-1:0]        tag_out
);

    localparam int unsigned FmaLen = fma_len(NF);
    localparam int unsigned PmLen  = pm_len(NF);

    logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic adv2, accept, load2;

    logic [FmaLen-1:0] s1_am_q;
    logic              s1_sticky_q, s1_kill_q, s1_ps_q, s1_zs_q;
    logic [PmLen-1:0]  s1_pm_q;
    logic [NE+1:0]     s1_pe_q;
    logic [NE-1:0]     s1_ze_q;
    logic [TAGW-1:0]   s1_tag_q;

    logic [FmaLen-1:0] sum_sm;
    logic              sum_ss, sum_neg, sum_inv;
    logic [NE+1:0]     sum_se;

    logic [FmaLen-1:0] s2_sm_q;
    logic              s2_ss_q, s2_neg_q, s2_inv_q, s2_sticky_q;
    logic [NE+1:0]     s2_se_q;
    logic [TAGW-1:0]   s2_tag_q;

    assign adv2     = ~s2_valid_q | out_ready;
    assign in_ready = ~s1_valid_q | adv2;
    assign accept   = in_valid & in_ready;
    assign load2    = adv2 & s1_valid_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (accept) begin
            s1_valid_d = 1'b1;
        end else if (adv2) begin
            s1_valid_d = 1'b0;
        end
        s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s1_am_q     <= '0;
            s1_sticky_q <= 1'b0;
            s1_kill_q   <= 1'b0;
            s1_pm_q     <= '0;
            s1_ps_q     <= 1'b0;
            s1_zs_q     <= 1'b0;
            s1_pe_q     <= '0;
            s1_ze_q     <= '0;
            s1_tag_q    <= '0;
            s2_sm_q     <= '0;
            s2_ss_q     <= 1'b0;
            s2_se_q     <= '0;
            s2_neg_q    <= 1'b0;
            s2_inv_q    <= 1'b0;
            s2_sticky_q <= 1'b0;
            s2_tag_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (accept) begin
                s1_am_q     <= Am;
                s1_sticky_q <= ASticky;
                s1_kill_q   <= KillProd;
                s1_pm_q     <= Pm;
                s1_ps_q     <= Ps;
                s1_zs_q     <= Zs;
                s1_pe_q     <= Pe;
                s1_ze_q     <= Ze;
                s1_tag_q    <= tag_in;
            end
            if (load2) begin
                s2_sm_q     <= sum_sm;
                s2_ss_q     <= sum_ss;
                s2_se_q     <= sum_se;
                s2_neg_q    <= sum_neg;
                s2_inv_q    <= sum_inv;
                s2_sticky_q <= s1_sticky_q;
                s2_tag_q    <= s1_tag_q;
            end
        end
    end

    fmaaddsum #(
        .NF(NF),
        .NE(NE)
    ) u_sum (
        .am_i       (s1_am_q),
        .asticky_i  (s1_sticky_q),
        .kill_prod_i(s1_kill_q),
        .pm_i       (s1_pm_q),
        .ps_i       (s1_ps_q),
        .zs_i       (s1_zs_q),
        .pe_i       (s1_pe_q),
        .ze_i       (s1_ze_q),
        .sm_o       (sum_sm),
        .ss_o       (sum_ss),
        .se_o       (sum_se),
        .neg_sum_o  (sum_neg),
        .inv_a_o    (sum_inv)
    );

    assign out_valid = s2_valid_q;
    assign Sm        = s2_sm_q;
    assign Ss        = s2_ss_q;
    assign Se        = s2_se_q;
    assign NegSum    = s2_neg_q;
    assign InvA      = s2_inv_q;
    assign ASticky_o = s2_sticky_q;
    assign tag_out   = s2_tag_q;

endmodule
